// File: rtl/vx_tcu_drl_fp32to16_if.sv
// Valid/ready bundle for the FP32->FP16 down-converter: operand side plus result side.
// The master drives operands and result back-pressure; the converter is the slave.
interface vx_tcu_drl_fp32to16_if #(
   parameter int TAG_WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_data;
   logic [TAG_WIDTH-1:0] in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [15:0]          out_data;
   logic [TAG_WIDTH-1:0] out_tag;
   logic [3:0]           out_fflags;

   modport master (
      output in_valid, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_fflags
   );

   modport slave (
      input  in_valid, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_fflags
   );
endinterface

// File: rtl/vx_tcu_drl_fp32to16.sv
// Two-stage FP32 -> FP16 converter (RNE, IEEE specials, {NV,OF,UF,NX} flags).
// Define TCU_DRL_FP32TO16_DENORM_EN to produce FP16 subnormals; otherwise tiny results flush to zero.
module vx_tcu_drl_fp32to16 #(
   parameter int TAG_WIDTH = 8
) (
   input logic                  clk,
   input logic                  reset_n,
   vx_tcu_drl_fp32to16_if.slave bus
);

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_DENORM,
      CLS_NORMAL,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } fp_class_e;

   localparam logic [3:0] FLAG_NV = 4'b1000;
   localparam logic [3:0] FLAG_OF = 4'b0100;
   localparam logic [3:0] FLAG_UF = 4'b0010;
   localparam logic [3:0] FLAG_NX = 4'b0001;

   // ---------------- stage 1: classify and rebias ----------------
   logic [7:0]        in_exp;
   logic [22:0]       in_frac;
   logic signed [8:0] in_e16;
   fp_class_e         in_cls;

   assign in_exp  = bus.in_data[30:23];
   assign in_frac = bus.in_data[22:0];
   assign in_e16  = $signed({1'b0, in_exp}) - 9'sd112;

   always_comb begin
      in_cls = CLS_NORMAL;
      if (in_exp == 8'h00) begin
         in_cls = (in_frac == '0) ? CLS_ZERO : CLS_DENORM;
      end else if (in_exp == 8'hFF) begin
         if (in_frac == '0)     in_cls = CLS_INF;
         else if (in_frac[22])  in_cls = CLS_QNAN;
         else                   in_cls = CLS_SNAN;
      end
   end

   logic                 s1_valid;
   logic                 s1_sign;
   fp_class_e            s1_cls;
   logic signed [8:0]    s1_e16;
   logic [22:0]          s1_frac;
   logic [TAG_WIDTH-1:0] s1_tag;

   logic s2_advance;
   logic accept;

   // Output register drains when empty or taken; stage 1 refills whenever it empties or drains.
   assign s2_advance   = ~bus.out_valid | bus.out_ready;
   assign bus.in_ready = ~s1_valid | s2_advance;
   assign accept       = bus.in_valid & bus.in_ready;

   // NOTE: operand registers have no reset; nothing reads them unless s1_valid is set.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_sign <= bus.in_data[31];
         s1_cls  <= in_cls;
         s1_e16  <= in_e16;
         s1_frac <= in_frac;
         s1_tag  <= bus.in_tag;
      end
   end

   // ---------------- stage 2: round and pack ----------------
   logic        norm_guard;
   logic        norm_sticky;
   logic        norm_up;
   logic [14:0] norm_sum;

   // Exponent and mantissa sit side by side so a mantissa carry bumps the exponent for free.
   assign norm_guard  = s1_frac[12];
   assign norm_sticky = |s1_frac[11:0];
   assign norm_up     = norm_guard & (norm_sticky | s1_frac[13]);
   assign norm_sum    = {s1_e16[4:0], s1_frac[22:13]} + {14'd0, norm_up};

   logic [15:0] tiny_data;
   logic [3:0]  tiny_flags;

`ifdef TCU_DRL_FP32TO16_DENORM_EN
   logic [23:0] tiny_sig;
   logic [4:0]  tiny_shift;
   logic [9:0]  tiny_m;
   logic [25:0] tiny_lost;
   logic        tiny_guard;
   logic        tiny_sticky;
   logic        tiny_up;
   logic [10:0] tiny_sum;

   // Any shift of 25 or more leaves only sticky bits, so the shifter is capped there.
   assign tiny_sig    = {1'b1, s1_frac};
   assign tiny_shift  = (s1_e16 < -9'sd11) ? 5'd25 : 5'(9'sd14 - s1_e16);
   assign tiny_m      = 10'(tiny_sig >> tiny_shift);
   assign tiny_lost   = 26'({tiny_sig, 26'd0} >> tiny_shift);
   assign tiny_guard  = tiny_lost[25];
   assign tiny_sticky = |tiny_lost[24:0];
   assign tiny_up     = tiny_guard & (tiny_sticky | tiny_m[0]);
   assign tiny_sum    = {1'b0, tiny_m} + {10'd0, tiny_up};
   assign tiny_data   = {s1_sign, 4'd0, tiny_sum};
   assign tiny_flags  = (tiny_guard | tiny_sticky) ? (FLAG_UF | FLAG_NX) : 4'd0;
`else
   assign tiny_data   = {s1_sign, 15'd0};
   assign tiny_flags  = FLAG_UF | FLAG_NX;
`endif

   logic [15:0] res_data;
   logic [3:0]  res_flags;

   always_comb begin
      res_data  = {s1_sign, 15'd0};
      res_flags = 4'd0;
      case (s1_cls)
         CLS_ZERO:   ;
         CLS_DENORM: res_flags = FLAG_UF | FLAG_NX;
         CLS_INF:    res_data  = {s1_sign, 15'h7C00};
         CLS_QNAN:   res_data  = 16'h7E00;
         CLS_SNAN: begin
            res_data  = 16'h7E00;
            res_flags = FLAG_NV;
         end
         CLS_NORMAL: begin
            if (s1_e16 >= 9'sd31) begin
               res_data  = {s1_sign, 15'h7C00};
               res_flags = FLAG_OF | FLAG_NX;
            end else if (s1_e16 >= 9'sd1) begin
               res_data  = {s1_sign, norm_sum};
               res_flags = {1'b0, norm_sum[14:10] == 5'h1F, 1'b0, norm_guard | norm_sticky};
            end else begin
               res_data  = tiny_data;
               res_flags = tiny_flags;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid       <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.out_data   <= 16'h0000;
         bus.out_tag    <= '0;
         bus.out_fflags <= 4'd0;
      end else begin
         if (bus.in_ready) s1_valid <= bus.in_valid;
         if (s2_advance) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
               bus.out_data   <= res_data;
               bus.out_tag    <= s1_tag;
               bus.out_fflags <= res_flags;
            end
         end
      end
   end

endmodule

// File: tb/tb_vx_tcu_drl_fp32to16.sv
// Self-checking bench for vx_tcu_drl_fp32to16: directed vectors, back-pressure stream, reset flush.
// Honours TCU_DRL_FP32TO16_DENORM_EN the same way the design does.
module tb_vx_tcu_drl_fp32to16;
   localparam int TAG_WIDTH = 8;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   vx_tcu_drl_fp32to16_if #(.TAG_WIDTH(TAG_WIDTH)) bus ();

   vx_tcu_drl_fp32to16 #(.TAG_WIDTH(TAG_WIDTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference conversion by integer arithmetic on the real value: returns {fflags, data}.
   function automatic logic [19:0] model(input logic [31:0] x);
      logic        s;
      int          e, ue, sh;
      logic [22:0] f;
      longint      sig, q, rem, half, mag;
      logic        inexact, tiny;
      s = x[31];
      e = int'(x[30:23]);
      f = x[22:0];
      if (e == 255) begin
         if (f != 0) return {(f[22] ? 4'h0 : 4'h8), 16'h7E00};
         return {4'h0, s, 15'h7C00};
      end
      if (e == 0) return {((f != 0) ? 4'h3 : 4'h0), s, 15'h0000};
      ue   = e - 127;
      tiny = (ue < -14);
`ifndef TCU_DRL_FP32TO16_DENORM_EN
      if (tiny) return {4'h3, s, 15'h0000};
`endif
      if (ue > 15) return {4'h5, s, 15'h7C00};
      sh = 13 + (tiny ? (-14 - ue) : 0);
      if (sh > 40) sh = 40;
      sig  = longint'({1'b1, f});
      q    = sig >> sh;
      rem  = sig - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      inexact = (rem != 0);
      mag = tiny ? q : ((longint'(ue + 15) << 10) + q - 1024);
      if (mag >= 'h7C00) return {4'h5, s, 15'h7C00};
      return {2'b00, tiny && inexact, inexact, s, 15'(mag)};
   endfunction

   // ---------------- scoreboard / compare process ----------------
   typedef struct {
      logic [19:0]          exp;
      logic [TAG_WIDTH-1:0] tag;
      int                   cyc;
   } sb_t;

   sb_t                  sb[$];
   sb_t                  pop_e, push_e;
   int                   cycle  = 0;
   int                   n_emit = 0;
   bit                   lat_en = 0;
   bit                   hold_v = 0;
   logic [15:0]          hold_data;
   logic [TAG_WIDTH-1:0] hold_tag;
   logic [3:0]           hold_flags;

   always @(negedge clk) begin
      cycle++;
      if (!reset_n) begin
         sb.delete();
         hold_v = 0;
      end else begin
         if (hold_v) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_data",  bus.out_data, hold_data);
            check("hold_tag",   bus.out_tag, hold_tag);
            check("hold_flags", bus.out_fflags, hold_flags);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("spurious_emit", bus.out_valid, 0);
            end else begin
               pop_e = sb.pop_front();
               check($sformatf("data_tag%0h", pop_e.tag), bus.out_data, pop_e.exp[15:0]);
               check($sformatf("flags_tag%0h", pop_e.tag), bus.out_fflags, pop_e.exp[19:16]);
               check("tag_order", bus.out_tag, pop_e.tag);
               if (lat_en) check("latency", cycle - pop_e.cyc, 2);
               n_emit++;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            push_e.exp = model(bus.in_data);
            push_e.tag = bus.in_tag;
            push_e.cyc = cycle;
            sb.push_back(push_e);
         end
         hold_v     = bus.out_valid && !bus.out_ready;
         hold_data  = bus.out_data;
         hold_tag   = bus.out_tag;
         hold_flags = bus.out_fflags;
      end
   end

   // ---------------- stimulus ----------------
   bit rand_ready = 0;

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [31:0] d, input logic [TAG_WIDTH-1:0] t);
      bit done;
      done = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_tag   = t;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         done = bus.in_ready;
         step();
      end
      check("accept_in_time", {31'd0, done}, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 300 && sb.size() != 0; c++) step();
      check("drain_empty", sb.size(), 0);
   endtask

   typedef struct {
      logic [31:0] in;
      logic [15:0] d;
      logic [3:0]  f;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic [31:0] in, input logic [15:0] d, input logic [3:0] f);
      vec_t v;
      v.in = in;
      v.d  = d;
      v.f  = f;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int emit_snap;
      logic [31:0] stream [8];

      reset_n        = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_tag     = '0;
      bus.out_ready  = 1'b1;

      // Hand-computed expectations ({NV,OF,UF,NX}: 8,4,2,1).
      add_vec(32'h3F800000, 16'h3C00, 4'h0);
      add_vec(32'h477FE000, 16'h7BFF, 4'h0);
      add_vec(32'hC0000000, 16'hC000, 4'h0);
      add_vec(32'h3F801000, 16'h3C00, 4'h1);
      add_vec(32'h3F803000, 16'h3C02, 4'h1);
      add_vec(32'h477FF000, 16'h7C00, 4'h5);
      add_vec(32'h47800000, 16'h7C00, 4'h5);
      add_vec(32'h7F800001, 16'h7E00, 4'h8);
      add_vec(32'h7FC00000, 16'h7E00, 4'h0);
      add_vec(32'hFF800000, 16'hFC00, 4'h0);
      add_vec(32'h00000001, 16'h0000, 4'h3);
      add_vec(32'h80000000, 16'h8000, 4'h0);
      add_vec(32'h38800000, 16'h0400, 4'h0);
`ifdef TCU_DRL_FP32TO16_DENORM_EN
      add_vec(32'h33800000, 16'h0001, 4'h0);
      add_vec(32'h33000001, 16'h0001, 4'h3);
      add_vec(32'h387FF000, 16'h0400, 4'h3);
`else
      add_vec(32'h33800000, 16'h0000, 4'h3);
      add_vec(32'hB87FF000, 16'h8000, 4'h3);
`endif

      foreach (vecs[i])
         check($sformatf("model_%08h", vecs[i].in), model(vecs[i].in), {vecs[i].f, vecs[i].d});

      // Reset state.
      repeat (3) step();
      check("rst_out_valid",  bus.out_valid, 0);
      check("rst_in_ready",   bus.in_ready, 1);
      reset_n = 1'b1;
      step();
      check("post_rst_out_valid", bus.out_valid, 0);
      check("post_rst_out_data",  bus.out_data, 16'h0000);
      check("post_rst_out_tag",   bus.out_tag, 0);
      check("post_rst_out_flags", bus.out_fflags, 0);
      check("post_rst_in_ready",  bus.in_ready, 1);

      // Directed vectors, back to back, no stall: latency checked on every result.
      lat_en = 1;
      foreach (vecs[i]) send(vecs[i].in, TAG_WIDTH'(i));
      drain();
      lat_en = 0;

      // Back-pressure stream with random out_ready.
      stream = '{32'h40490FDB, 32'hC2F6E979, 32'h3DCCCCCD, 32'h477FF000,
                 32'h38800000, 32'h7F800001, 32'h00000000, 32'h3F7FF000};
      emit_snap  = n_emit;
      rand_ready = 1;
      foreach (stream[i]) send(stream[i], TAG_WIDTH'(8'hA0 + i));
      drain();
      rand_ready = 0;
      check("stream_count", n_emit - emit_snap, 8);

      // Stalled output: in_ready falls after two accepts.
      bus.out_ready = 1'b0;
      step();
      send(32'h3F800000, 8'hC1);
      check("in_ready_after_1", bus.in_ready, 1);
      send(32'h40000000, 8'hC2);
      check("in_ready_after_2", bus.in_ready, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h40400000;
      bus.in_tag   = 8'hC3;
      repeat (3) begin
         step();
         check("in_ready_stalled", bus.in_ready, 0);
      end
      check("stalled_out_valid", bus.out_valid, 1);
      check("stalled_out_tag",   bus.out_tag, 8'hC1);
      bus.in_valid = 1'b0;

      // Reset with two results in flight: all dropped, nothing emitted afterwards.
      emit_snap = n_emit;
      reset_n   = 1'b0;
      #1;
      check("rst_flush_out_valid", bus.out_valid, 0);
      check("rst_flush_out_data",  bus.out_data, 16'h0000);
      step();
      step();
      reset_n       = 1'b1;
      bus.out_ready = 1'b1;
      repeat (10) step();
      check("no_emit_after_reset", n_emit - emit_snap, 0);
      check("idle_out_valid", bus.out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
